bus_req_arbiter: RTL

//  Round-robin arbiter between the CPUS L1 requesters (I$/D$ per hart) on the shared coherence bus.

---
 rtl/bus_req_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/bus_req_arbiter.sv
// Round-robin arbiter for the L1 requesters on the shared coherence bus.
// It picks one requester, latches that request's class and holds the grant until
// the bus controller finishes. A hold-time watchdog releases grants that never complete.
module bus_req_arbiter #(
    parameter  int unsigned CPUS     = 4,
    parameter  int unsigned MAX_HOLD = 1024,
    localparam int unsigned IDXW     = $clog2(CPUS)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [CPUS-1:0] dREN,
    input  logic [CPUS-1:0] dWEN,
    input  logic [CPUS-1:0] ccwrite,
    input  logic [CPUS-1:0] ccabort,
    input  logic            txn_done,
    output logic            grant_valid,
    output logic [CPUS-1:0] grant_onehot,
    output logic [IDXW-1:0] grant_idx,
    output logic [1:0]      grant_type,
    output logic            timeout
);

    localparam int unsigned   HCW       = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HCW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HCW'(MAX_HOLD - 1);
    localparam logic [HCW-1:0] HOLD_SAT  = '1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(CPUS - 1);

    localparam logic [1:0] CLS_R     = 2'd0;
    localparam logic [1:0] CLS_RX    = 2'd1;
    localparam logic [1:0] CLS_EVICT = 2'd2;
    localparam logic [1:0] CLS_INV   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IDXW-1:0] rr_ptr;
    logic [HCW-1:0]  hold_cnt;

    logic [CPUS-1:0] req_c;
    logic            pick_found;
    logic [IDXW-1:0] pick_idx;
    int unsigned     cand;
    logic [IDXW-1:0] cand_idx;
    logic            lines_c;
    logic            abort_c;
    logic            wd_c;
    logic            release_c;
    logic            timeout_c;

    logic            valid_n;
    logic [CPUS-1:0] onehot_n;
    logic [IDXW-1:0] idx_n;
    logic [1:0]      type_n;
    logic            timeout_n;
    logic [IDXW-1:0] rr_n;
    logic [HCW-1:0]  hold_n;

    // Request class; eviction dominates, then read-exclusive, read, invalidate.
    function automatic logic [1:0] req_class(input logic ren, input logic wen, input logic ccw);
        if (wen)             return CLS_EVICT;
        else if (ren && ccw) return CLS_RX;
        else if (ren)        return CLS_R;
        else                 return CLS_INV;
    endfunction

    assign req_c = (dREN | dWEN | ccwrite) & ~ccabort;

    // Round-robin scan starting at rr_ptr, wrapping without a modulo.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int k = 0; k < CPUS; k++) begin
            cand = 32'(rr_ptr) + 32'(k);
            if (cand >= CPUS) cand = cand - CPUS;
            cand_idx = IDXW'(cand);
            if (!pick_found && req_c[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // Release causes for the held grant, all evaluated in the same cycle.
    always_comb begin
        lines_c   = dREN[grant_idx] | dWEN[grant_idx] | ccwrite[grant_idx];
        abort_c   = ccabort[grant_idx];
        wd_c      = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
        release_c = txn_done | abort_c | ~lines_c | wd_c;
        timeout_c = wd_c & ~txn_done & ~abort_c;
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (pick_found) state_nxt = S_GRANT;
            S_GRANT:   if (release_c)  state_nxt = S_RELEASE;
            S_RELEASE: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Next values for the registered outputs and the pointer/counter.
    always_comb begin
        valid_n   = grant_valid;
        onehot_n  = grant_onehot;
        idx_n     = grant_idx;
        type_n    = grant_type;
        timeout_n = 1'b0;
        rr_n      = rr_ptr;
        hold_n    = hold_cnt;
        case (state)
            S_IDLE: begin
                if (pick_found) begin
                    valid_n           = 1'b1;
                    onehot_n          = '0;
                    onehot_n[pick_idx] = 1'b1;
                    idx_n             = pick_idx;
                    type_n            = req_class(dREN[pick_idx], dWEN[pick_idx], ccwrite[pick_idx]);
                    hold_n            = '0;
                end
            end
            S_GRANT: begin
                if (hold_cnt != HOLD_SAT) hold_n = hold_cnt + HCW'(1);
                if (release_c) begin
                    valid_n   = 1'b0;
                    onehot_n  = '0;
                    timeout_n = timeout_c;
                end
            end
            S_RELEASE: begin
                rr_n = (grant_idx == LAST_IDX) ? '0 : grant_idx + IDXW'(1);
            end
            default: begin
                valid_n  = 1'b0;
                onehot_n = '0;
            end
        endcase
    end

    // Output, pointer and hold-counter registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            grant_valid  <= 1'b0;
            grant_onehot <= '0;
            grant_idx    <= '0;
            grant_type   <= '0;
            timeout      <= 1'b0;
            rr_ptr       <= '0;
            hold_cnt     <= '0;
        end else begin
            grant_valid  <= valid_n;
            grant_onehot <= onehot_n;
            grant_idx    <= idx_n;
            grant_type   <= type_n;
            timeout      <= timeout_n;
            rr_ptr       <= rr_n;
            hold_cnt     <= hold_n;
        end
    end

endmodule
